serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial, LSB-first WIDTH-bit subtractor computing `a - b` over WIDTH clock cycles with a start/busy/done handshake. It is the inverse-operation counterpart to the arithmetic cells in the datapath practice set. It reuses a single one-bit mux-based full-subtractor cell in place of a WIDTH-bit ripple array, and sits between a control block that issues operand pairs and a consumer that samples the result on `done`.

## Interface
- `WIDTH`, default 8, operand/result width; legal range 2..32.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  **asynchronous, active-low reset**.
- `start`  input  1  request; sampled only in IDLE.
- `a`  input  WIDTH  minuend; sampled with `start`.
- `b`  input  WIDTH  subtrahend; sampled with `start`.
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle pulse; result valid.
- `diff`  output  WIDTH  `a - b` mod 2^WIDTH; held until the next completion.
- `borrow`  output  1  final borrow-out (`a < b` unsigned).
- `ovf`  output  1  signed overflow; see Configuration.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on `start`=1.
  - RUN → DONE when the bit counter reaches WIDTH-1.
  - DONE → IDLE unconditionally.
- IDLE with `start`:
  - load `a` and `b` into internal shift registers;
  - clear the internal borrow flop and the bit counter.
- RUN, each cycle:
  - the cell takes `ai=a_sh[0]`, `bi=b_sh[0]`, `bin=borrow_q`;
  - it produces `d = ai^bi^bin` and `bout = (~ai&bi) | (~(ai^bi)&bin)`;
  - `d` is shifted into the MSB of the result shift register, so bit 0 lands at LSB after WIDTH shifts;
  - `a_sh` and `b_sh` shift right, `borrow_q <= bout`, and the counter increments.
- On the RUN→DONE edge:
  - `diff` is loaded from the result shift register with the final `d` included;
  - `borrow` is loaded with the final `bout`.
- `start` is ignored in RUN and DONE. Operands presented then are discarded, with no queueing.
- `a` and `b` are only sampled on the accepting edge. Later changes have no effect.
- `diff`, `borrow` and `ovf` do not change during RUN. They hold the previous result.
- Reset values: state IDLE, `busy`=0, `done`=0, `diff`=0, `borrow`=0, `ovf`=0, counter, shift registers and `borrow_q` all 0.
- Reset asserted mid-operation aborts immediately:
  - all outputs return to their reset values;
  - no `done` is produced;
  - after deassertion the block waits in IDLE.

## Timing
- `start` accepted at edge k:
  - `busy`=1 after edges k .. k+WIDTH-1;
  - the WIDTH bit-processing edges are k+1 .. k+WIDTH;
  - `done`=1 and the result is valid in the cycle after edge k+WIDTH;
  - `busy`=0 in that same cycle.
- `done` is high for exactly one cycle. The next `start` is accepted at edge k+WIDTH+2 at the earliest.
- Throughput is one subtraction per WIDTH+2 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- `SERIAL_SUB_SIGNED_OVF_EN` defined:
  - on the RUN→DONE edge, `ovf <= (a_msb ^ b_msb) & (a_msb ^ d_final)`;
  - `a_msb` and `b_msb` are captured at start;
  - `ovf` is held alongside `diff`.
- Not defined:
  - `ovf` is tied to constant 0;
  - no MSB capture flops are synthesised;
  - the port remains present.

## Structure
- Shared package `serial_sub_pkg`:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - counter width function `$clog2(WIDTH)`.
- One sub-module, `full_subtractor_mux`: combinational 1-bit cell, ports `ai, bi, bin, d, bout`, with `d` built as a mux on `ai` selecting `~(bi^bin)` or `bi^bin`.
- The top level holds the FSM, counter, shift registers and output registers.

## Test plan
- WIDTH=8, `a`=0x05, `b`=0x03, start at edge k → `done` in the cycle after edge k+8, `diff`=0x02, `borrow`=0, `ovf`=0.
- `a`=0x03, `b`=0x05 → `diff`=0xFE, `borrow`=1; `ovf`=0.
- `a`=0x80, `b`=0x01 → `diff`=0x7F, `borrow`=0.
  - `ovf`=1 with the macro defined.
  - `ovf`=0 without it.
- `a`=0x00, `b`=0x00, then `a`=0xFF, `b`=0xFF back-to-back (second start asserted continuously from the first `done` cycle) → both `diff`=0x00 and `borrow`=0. Second start accepted exactly WIDTH+2 cycles after the first.
- Start with 0x10−0x01, then pulse `start` with 0x00−0x01 mid-RUN → ignored; single `done` with `diff`=0x0F; `diff` unchanged during RUN.
- Assert `rst_n`=0 four cycles into RUN → `busy`, `done`, `diff`, `borrow` go to 0 asynchronously. No `done` follows. The next start completes normally.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg -- shared definitions for the bit-serial subtractor.
//   state_t : FSM encoding (IDLE=0, RUN=1, DONE=2)
//   cnt_w() : bit-counter width for a given operand width
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter only has to reach WIDTH-1. The floor of 1 keeps the vector legal.
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/full_subtractor_mux.sv
// full_subtractor_mux -- combinational 1-bit full subtractor.
//   ai   : minuend bit
//   bi   : subtrahend bit
//   bin  : borrow in
//   d    : difference bit, ai ^ bi ^ bin, built as a mux on ai
//   bout : borrow out
module full_subtractor_mux (
  input  logic ai,
  input  logic bi,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_x;

  assign w_x  = bi ^ bin;
  // ai selects between the inverted and the true parity of bi/bin.
  assign d    = ai ? ~w_x : w_x;
  assign bout = (~ai & bi) | (~(ai ^ bi) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor -- LSB-first bit-serial a - b over WIDTH cycles.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start      : request, accepted only in IDLE (a, b sampled then)
//   a, b       : minuend / subtrahend
//   busy       : high while bits are being processed
//   done       : one-cycle pulse, result valid
//   diff       : a - b mod 2^WIDTH, held until the next completion
//   borrow     : final borrow out (a < b unsigned)
//   ovf        : signed overflow when SERIAL_SUB_SIGNED_OVF_EN is defined,
//                otherwise constant 0
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CW = cnt_w(WIDTH);

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a_sh, r_b_sh;
  // The LSB of a full-width result register would never be read, so the
  // register keeps only the upper WIDTH-1 bits; the new bit completes it.
  logic [WIDTH-2:0] r_res;
  logic             r_borrow_q;
  logic             r_busy, r_done, r_borrow;
  logic [WIDTH-1:0] r_diff;
  logic             w_d, w_bout, w_last;
  logic [WIDTH-1:0] w_res_nxt;

  full_subtractor_mux u_cell (
    .ai   (r_a_sh[0]),
    .bi   (r_b_sh[0]),
    .bin  (r_borrow_q),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_last    = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));
  assign w_res_nxt = {w_d, r_res};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_a_sh     <= '0;
      r_b_sh     <= '0;
      r_res      <= '0;
      r_borrow_q <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_diff     <= '0;
      r_borrow   <= 1'b0;
    end else begin
      // Status flags follow the next state so they are true flops.
      r_busy <= (w_state_nxt == RUN);
      r_done <= (w_state_nxt == DONE);
      case (r_state)
        IDLE: if (start) begin
          r_a_sh     <= a;
          r_b_sh     <= b;
          r_borrow_q <= 1'b0;
          r_cnt      <= '0;
        end
        RUN: begin
          r_a_sh     <= r_a_sh >> 1;
          r_b_sh     <= r_b_sh >> 1;
          r_borrow_q <= w_bout;
          r_cnt      <= r_cnt + CW'(1);
          r_res      <= w_res_nxt[WIDTH-1:1];
          if (w_last) begin
            r_diff   <= w_res_nxt;
            r_borrow <= w_bout;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic r_a_msb, r_b_msb, r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (r_state == IDLE && start) begin
        r_a_msb <= a[WIDTH-1];
        r_b_msb <= b[WIDTH-1];
      end
      // Operands of differing sign whose result sign differs from a.
      if (w_last) r_ovf <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
    end
  end

  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  assign busy   = r_busy;
  assign done   = r_done;
  assign diff   = r_diff;
  assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, borrow, ovf;
  logic [W-1:0] diff;

  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] prev_diff;
  logic         prev_borrow, prev_ovf;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain modular / signed arithmetic on the operands.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] d, output logic br, output logic ov);
    int sx, sy, r;
    d  = x - y;
    br = (x < y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    r  = sx - sy;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ov = (r > 127) || (r < -128);
`else
    ov = 1'b0;
    if (r == 1000) ov = 1'b1; // unreachable: 8-bit operands keep r in range
`endif
  endtask

  // Called at a negedge; drives start and waits for busy, bounded.
  task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y,
                        input int exp_lat, input string tag);
    int lat = 0;
    start = 1'b1; a = x; b = y;
    while (!busy && lat < 4) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    start = 1'b0;
    a = W'($urandom); b = W'($urandom);
    chk({tag, " accept latency"}, lat, exp_lat);
  endtask

  // Follows the run after launch; ends at the negedge of the done cycle.
  task automatic finish(input logic [W-1:0] x, input logic [W-1:0] y,
                        input bit inject, input string tag);
    logic [W-1:0] ed;
    logic         eb, eo;
    model(x, y, ed, eb, eo);
    for (int i = 1; i <= W; i++) begin
      @(posedge clk); @(negedge clk);
      a = W'($urandom); b = W'($urandom);
      if (inject && i == 2) begin start = 1'b1; a = 8'h00; b = 8'h01; end
      else if (inject && i == 3) start = 1'b0;
      if (i < W) begin
        chk({tag, " busy in run"}, busy, 1'b1);
        chk({tag, " no early done"}, done, 1'b0);
        chk({tag, " diff held"}, diff, prev_diff);
        chk({tag, " borrow held"}, borrow, prev_borrow);
        chk({tag, " ovf held"}, ovf, prev_ovf);
      end else begin
        chk({tag, " done"}, done, 1'b1);
        chk({tag, " busy low at done"}, busy, 1'b0);
        chk({tag, " diff"}, diff, ed);
        chk({tag, " borrow"}, borrow, eb);
        chk({tag, " ovf"}, ovf, eo);
      end
    end
    prev_diff = ed; prev_borrow = eb; prev_ovf = eo;
  endtask

  task automatic idle1(input string tag);
    @(posedge clk); @(negedge clk);
    chk({tag, " done one cycle"}, done, 1'b0);
    chk({tag, " idle busy"}, busy, 1'b0);
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
    launch(x, y, 1, tag);
    finish(x, y, 1'b0, tag);
    idle1(tag);
  endtask

  initial begin
    int seen;
    logic [W-1:0] rx, ry, nx, ny;
    prev_diff = '0; prev_borrow = 1'b0; prev_ovf = 1'b0;
    #12;
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset diff", diff, '0);
    chk("reset borrow", borrow, 1'b0);
    chk("reset ovf", ovf, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    op(8'h05, 8'h03, "5-3");
    op(8'h03, 8'h05, "3-5");
    op(8'h80, 8'h01, "80-1");

    // Back-to-back: second start held from the done cycle.
    launch(8'h00, 8'h00, 1, "0-0");
    finish(8'h00, 8'h00, 1'b0, "0-0");
    launch(8'hFF, 8'hFF, 2, "FF-FF b2b");
    finish(8'hFF, 8'hFF, 1'b0, "FF-FF b2b");
    idle1("FF-FF b2b");

    // Start pulsed mid-run must be dropped.
    launch(8'h10, 8'h01, 1, "inject");
    finish(8'h10, 8'h01, 1'b1, "inject");
    idle1("inject");
    chk("inject no second busy", busy, 1'b0);

    // Asynchronous reset four cycles into a run.
    launch(8'h37, 8'h12, 1, "rst");
    repeat (4) begin @(posedge clk); @(negedge clk); end
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", busy, 1'b0);
    chk("async rst done", done, 1'b0);
    chk("async rst diff", diff, '0);
    chk("async rst borrow", borrow, 1'b0);
    chk("async rst ovf", ovf, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (W + 3) begin
      @(posedge clk); @(negedge clk);
      if (done || busy) seen++;
    end
    chk("no done after rst", seen, 0);
    prev_diff = '0; prev_borrow = 1'b0; prev_ovf = 1'b0;
    op(8'h10, 8'h01, "post rst");

    // Random operands, some back-to-back.
    for (int n = 0; n < 30; n++) begin
      rx = W'($urandom); ry = W'($urandom);
      launch(rx, ry, 1, "rand");
      finish(rx, ry, 1'b0, "rand");
      if ($urandom_range(0, 1) == 1) begin
        nx = W'($urandom); ny = W'($urandom);
        launch(nx, ny, 2, "rand b2b");
        finish(nx, ny, 1'b0, "rand b2b");
      end
      idle1("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
